// File: rtl/aging_uart_pkg.sv
// Shared definitions for the aging-sensor UART link (encoder and decoder).
package aging_uart_pkg;
  localparam logic [3:0] TAG_A0 = 4'd0;
  localparam logic [3:0] TAG_A1 = 4'd1;
  localparam logic [3:0] TAG_A2 = 4'd2;
  localparam logic [3:0] TAG_A3 = 4'd3;
  localparam logic [3:0] TAG_A4 = 4'd4;
  localparam logic [3:0] TAG_I0 = 4'd5;
  localparam logic [3:0] TAG_I1 = 4'd6;
  localparam logic [3:0] TAG_I2 = 4'd7;
  localparam logic [3:0] TAG_I3 = 4'd8;
  localparam logic [3:0] TAG_I4 = 4'd9;

  localparam int unsigned FRAME_LEN   = 10;
  localparam int unsigned NIB_PER_VAL = 5;
  localparam int unsigned SENSOR_W    = 20;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;
endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: expires on the idle cycle that would make the count reach TIMEOUT_CYCLES.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CNT_W-1:0] r_cnt;

  // A zero timeout parameter disables expiry altogether.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (r_cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || expired) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart2aging_dec.sv
// Aging-sensor UART frame decoder: reassembles the 20-bit ALU and IU values from tagged nibbles.
// state   | meaning
// HUNT    | waiting for a tag-0 byte to open a frame
// COLLECT | frame open, expecting tag r_exp next
module uart2aging_dec
  import aging_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned ERRCNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          RxData_i,
  input  logic                RxValid_i,
  output logic [19:0]         DataAlu_o,
  output logic [19:0]         DataIu_o,
  output logic                Valid_o,
  output logic                FrameErr_o,
  output logic [ERRCNT_W-1:0] ErrCnt_o,
  output logic                InFrame_o
);
  state_e      r_state;
  logic [3:0]  r_exp;
  logic [19:0] r_alu_sh;
  logic [15:0] r_iu_sh;

  logic [3:0]  w_tag;
  logic [3:0]  w_nib;
  logic        w_collect;
  logic        w_match;
  logic        w_commit;
  logic        w_abort;
  logic        w_expired;
  logic [4:0]  w_sh_alu;
  logic [3:0]  w_sh_iu;

  assign w_tag     = RxData_i[7:4];
  assign w_nib     = RxData_i[3:0];
  assign w_collect = (r_state == COLLECT);
  assign w_match   = RxValid_i && (w_tag == r_exp);
  assign w_commit  = w_collect && w_match && (r_exp == TAG_I4);
  // A byte in the expiry cycle wins, since the timer is not enabled then.
  assign w_abort   = w_collect && (RxValid_i ? (w_tag != r_exp) : w_expired);
  assign w_sh_alu  = {r_exp[2:0], 2'b00};
  // IU slots 5..8 map to 0..3; subtracting one from the low two bits does that mapping.
  assign w_sh_iu   = {r_exp[1:0] - 2'd1, 2'b00};
  assign InFrame_o = w_collect;

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (RxValid_i || !w_collect),
    .en     (w_collect && !RxValid_i),
    .expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_exp      <= '0;
      r_alu_sh   <= '0;
      r_iu_sh    <= '0;
      DataAlu_o  <= '0;
      DataIu_o   <= '0;
      Valid_o    <= 1'b0;
      FrameErr_o <= 1'b0;
      ErrCnt_o   <= '0;
    end else begin
      Valid_o    <= w_commit;
      FrameErr_o <= w_abort;
      if (w_abort && (ErrCnt_o != '1)) begin
        ErrCnt_o <= ErrCnt_o + 1'b1;
      end

      case (r_state)
        HUNT: begin
          if (RxValid_i && (w_tag == TAG_A0)) begin
            r_alu_sh[3:0] <= w_nib;
            r_exp         <= TAG_A1;
            r_state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_commit) begin
            DataAlu_o <= r_alu_sh;
            DataIu_o  <= {w_nib, r_iu_sh};
            r_exp     <= TAG_A0;
            r_state   <= HUNT;
          end else if (w_match) begin
            if (r_exp < TAG_I0) begin
              r_alu_sh <= (r_alu_sh & ~(20'hF << w_sh_alu)) | (20'(w_nib) << w_sh_alu);
            end else begin
              r_iu_sh <= (r_iu_sh & ~(16'hF << w_sh_iu)) | (16'(w_nib) << w_sh_iu);
            end
            r_exp <= r_exp + 4'd1;
          end else if (RxValid_i && (w_tag == TAG_A0)) begin
            r_alu_sh[3:0] <= w_nib;
            r_exp         <= TAG_A1;
          end else if (w_abort) begin
            r_exp   <= TAG_A0;
            r_state <= HUNT;
          end
        end
        default: begin
          r_exp   <= TAG_A0;
          r_state <= HUNT;
        end
      endcase
    end
  end
endmodule
